// File: rtl/background_loader.sv
// background_loader: copies the selected arena map from the map ROM into the grid RAM
// and shares the grid RAM write port between the loader and the Blue/Red trail writers.
module background_loader #(
   parameter int CELLS  = 4800,
   parameter int ADDR_W = 13,
   parameter int CELL_W = 2
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              load_background,
   input  logic [1:0]        background_select,
   output logic              load_busy,
   output logic              load_done,
   output logic [ADDR_W+1:0] rom_addr,
   input  logic [CELL_W-1:0] rom_data,
   input  logic              Blue_req,
   input  logic [ADDR_W-1:0] Blue_addr,
   input  logic [CELL_W-1:0] Blue_data,
   output logic              Blue_ack,
   input  logic              Red_req,
   input  logic [ADDR_W-1:0] Red_addr,
   input  logic [CELL_W-1:0] Red_data,
   output logic              Red_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [CELL_W-1:0] ram_wdata,
   output logic              ram_we
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CELLS - 1);
   localparam logic [ADDR_W+1:0] CELLS_V  = (ADDR_W + 2)'(CELLS);

   function automatic logic [ADDR_W+1:0] map_base(input logic [1:0] sel);
      return {{ADDR_W{1'b0}}, sel} * CELLS_V;
   endfunction

   state_t              state_r, state_s;
   logic [ADDR_W-1:0]   idx_r, idx_s;
   logic [ADDR_W-1:0]   idx_d_r, idx_d_s;
   logic [ADDR_W+1:0]   base_r, base_s;
   logic [ADDR_W+1:0]   rom_addr_r, rom_addr_s;
   logic                load_busy_r, load_busy_s;
   logic                load_done_r, load_done_s;
   logic                last_red_r, last_red_s;
   logic                blue_ack_s, red_ack_s, ram_we_s;
   logic [ADDR_W-1:0]   ram_addr_s;
   logic [CELL_W-1:0]   ram_wdata_s;

   // State and datapath registers; last_red_r=1 means Red held the most recent grant.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r     <= IDLE;
         idx_r       <= '0;
         idx_d_r     <= '0;
         base_r      <= '0;
         rom_addr_r  <= '0;
         load_busy_r <= 1'b0;
         load_done_r <= 1'b0;
         last_red_r  <= 1'b1;
      end else begin
         state_r     <= state_s;
         idx_r       <= idx_s;
         idx_d_r     <= idx_d_s;
         base_r      <= base_s;
         rom_addr_r  <= rom_addr_s;
         load_busy_r <= load_busy_s;
         load_done_r <= load_done_s;
         last_red_r  <= last_red_s;
      end
   end

   // Next-state logic, load sequencing and write-port arbitration.
   always_comb begin
      state_s     = state_r;
      idx_s       = idx_r;
      idx_d_s     = idx_d_r;
      base_s      = base_r;
      rom_addr_s  = rom_addr_r;
      load_busy_s = 1'b0;
      load_done_s = 1'b0;
      last_red_s  = last_red_r;
      blue_ack_s  = 1'b0;
      red_ack_s   = 1'b0;
      ram_we_s    = 1'b0;
      ram_addr_s  = '0;
      ram_wdata_s = '0;
      case (state_r)
         IDLE, DONE: begin
            // Blue wins a tie only when Red was granted last.
            if (Blue_req && (!Red_req || last_red_r)) begin
               blue_ack_s  = 1'b1;
               ram_we_s    = 1'b1;
               ram_addr_s  = Blue_addr;
               ram_wdata_s = Blue_data;
               last_red_s  = 1'b0;
            end else if (Red_req) begin
               red_ack_s   = 1'b1;
               ram_we_s    = 1'b1;
               ram_addr_s  = Red_addr;
               ram_wdata_s = Red_data;
               last_red_s  = 1'b1;
            end else begin
               last_red_s  = last_red_r;
            end
            if (state_r == IDLE && load_background) begin
               state_s     = LOAD;
               idx_s       = '0;
               base_s      = map_base(background_select);
               rom_addr_s  = map_base(background_select);
               load_busy_s = 1'b1;
            end else begin
               state_s     = IDLE;
            end
         end
         LOAD: begin
            load_busy_s = 1'b1;
            idx_d_s     = idx_r;
            ram_we_s    = (idx_r != '0);
            ram_addr_s  = idx_d_r;
            ram_wdata_s = rom_data;
            if (idx_r == LAST_IDX) begin
               state_s = DRAIN;
            end else begin
               idx_s      = idx_r + ADDR_W'(1);
               rom_addr_s = base_r + {2'b00, idx_r + ADDR_W'(1)};
            end
         end
         DRAIN: begin
            ram_we_s    = 1'b1;
            ram_addr_s  = idx_d_r;
            ram_wdata_s = rom_data;
            load_done_s = 1'b1;
            state_s     = DONE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign load_busy = load_busy_r;
   assign load_done = load_done_r;
   assign rom_addr  = rom_addr_r;
   assign Blue_ack  = blue_ack_s & Reset_n;
   assign Red_ack   = red_ack_s & Reset_n;
   assign ram_we    = ram_we_s & Reset_n;
   assign ram_addr  = ram_addr_s;
   assign ram_wdata = ram_wdata_s;

endmodule

// File: tb/tb_background_loader.sv
// Directed bench for background_loader with CELLS=16, ADDR_W=4 and a registered
// map ROM model where cell i of map m holds (m+i)%4.
module tb_background_loader;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       load_background = 1'b0;
   logic [1:0] background_select = 2'd0;
   logic       load_busy, load_done;
   logic [5:0] rom_addr;
   logic [1:0] rom_data = 2'd0;
   logic       Blue_req = 1'b0, Red_req = 1'b0;
   logic [3:0] Blue_addr = 4'd0, Red_addr = 4'd0;
   logic [1:0] Blue_data = 2'd0, Red_data = 2'd0;
   logic       Blue_ack, Red_ack;
   logic [3:0] ram_addr;
   logic [1:0] ram_wdata;
   logic       ram_we;

   int n_cmp = 0;
   int n_err = 0;

   background_loader #(.CELLS(16), .ADDR_W(4), .CELL_W(2)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .load_background(load_background), .background_select(background_select),
      .load_busy(load_busy), .load_done(load_done),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .Blue_req(Blue_req), .Blue_addr(Blue_addr), .Blue_data(Blue_data), .Blue_ack(Blue_ack),
      .Red_req(Red_req), .Red_addr(Red_addr), .Red_data(Red_data), .Red_ack(Red_ack),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we)
   );

   always #5 Clk = ~Clk;

   // Registered ROM: map index in addr[5:4], cell index in addr[3:0].
   always @(posedge Clk) rom_data <= rom_addr[5:4] + rom_addr[1:0];

   typedef struct {
      logic       b_req;
      logic       r_req;
      logic [3:0] b_addr;
      logic [1:0] b_data;
      logic [3:0] r_addr;
      logic [1:0] r_data;
      logic       e_bak;
      logic       e_rak;
      logic [3:0] e_addr;
      logic [1:0] e_data;
   } arb_vec_t;

   arb_vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_load(input int sel, input int alt, input bit perturb,
                           input bit stall, input bit cowrite);
      int busy_cnt = 0, busy_last = 0, done_cnt = 0, done_k = 0, wr_cnt = 0;
      bit early_ack = 1'b0;
      background_select = 2'(sel);
      load_background   = 1'b1;
      if (cowrite) begin
         Red_req = 1'b1; Red_addr = 4'd8; Red_data = 2'd1;
         #1;
         check("start_red_ack", Red_ack, 1);
         check("start_red_addr", ram_addr, 8);
         check("start_busy", load_busy, 0);
      end
      @(posedge Clk);
      @(negedge Clk);
      load_background = 1'b0;
      Red_req = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (load_busy) begin busy_cnt++; busy_last = k; end
         if (load_done) begin done_cnt++; done_k = k; end
         if (k <= 16) check("rom_addr", rom_addr, sel * 16 + k - 1);
         if (k <= 17 && ram_we) begin
            check("load_wr_addr", ram_addr, wr_cnt);
            check("load_wr_data", ram_wdata, (sel + wr_cnt) % 4);
            wr_cnt++;
         end
         if (k <= 17 && Blue_ack) early_ack = 1'b1;
         if (stall && k == 18) begin
            check("stall_ack", Blue_ack, 1);
            check("stall_we", ram_we, 1);
            check("stall_addr", ram_addr, 5);
            check("stall_data", ram_wdata, 2);
            Blue_req = 1'b0;
         end
         if (stall && k == 2) begin
            Blue_req = 1'b1; Blue_addr = 4'd5; Blue_data = 2'd2;
         end
         if (perturb && (k == 3 || k == 18)) begin
            background_select = 2'(alt);
            load_background   = 1'b1;
         end else begin
            load_background   = 1'b0;
         end
         @(negedge Clk);
      end
      check("busy_cycles", busy_cnt, 17);
      check("busy_last", busy_last, 17);
      check("done_count", done_cnt, 1);
      check("done_cycle", done_k, 18);
      check("write_count", wr_cnt, 16);
      if (stall) check("stall_early_ack", early_ack, 0);
   endtask

   initial begin
      int done_cnt;
      //            breq  rreq  baddr  bdat   raddr  rdat   bak   rak   addr   data
      vecs[0] = '{1'b0, 1'b0, 4'd0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0};
      vecs[1] = '{1'b1, 1'b1, 4'd2, 2'd2, 4'd9, 2'd3, 1'b1, 1'b0, 4'd2, 2'd2};
      vecs[2] = '{1'b1, 1'b1, 4'd2, 2'd2, 4'd9, 2'd3, 1'b0, 1'b1, 4'd9, 2'd3};
      vecs[3] = '{1'b1, 1'b1, 4'd2, 2'd2, 4'd9, 2'd3, 1'b1, 1'b0, 4'd2, 2'd2};
      vecs[4] = '{1'b1, 1'b1, 4'd2, 2'd2, 4'd9, 2'd3, 1'b0, 1'b1, 4'd9, 2'd3};
      vecs[5] = '{1'b1, 1'b0, 4'd3, 2'd1, 4'd0, 2'd0, 1'b1, 1'b0, 4'd3, 2'd1};
      vecs[6] = '{1'b1, 1'b0, 4'd4, 2'd0, 4'd0, 2'd0, 1'b1, 1'b0, 4'd4, 2'd0};
      vecs[7] = '{1'b0, 1'b1, 4'd0, 2'd0, 4'd7, 2'd3, 1'b0, 1'b1, 4'd7, 2'd3};
      vecs[8] = '{1'b1, 1'b1, 4'd1, 2'd1, 4'd6, 2'd2, 1'b1, 1'b0, 4'd1, 2'd1};
      vecs[9] = '{1'b0, 1'b1, 4'd0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b1, 4'd0, 2'd0};

      #3;
      check("rst_busy", load_busy, 0);
      check("rst_done", load_done, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_we", ram_we, 0);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;

      // Arbitration in IDLE, starting from the reset priority (Red last).
      for (int i = 0; i < 10; i++) begin
         Blue_req = vecs[i].b_req; Blue_addr = vecs[i].b_addr; Blue_data = vecs[i].b_data;
         Red_req  = vecs[i].r_req; Red_addr  = vecs[i].r_addr; Red_data  = vecs[i].r_data;
         #1;
         check($sformatf("vec%0d_blue_ack", i), Blue_ack, vecs[i].e_bak);
         check($sformatf("vec%0d_red_ack", i), Red_ack, vecs[i].e_rak);
         check($sformatf("vec%0d_we", i), ram_we, vecs[i].e_bak | vecs[i].e_rak);
         if (vecs[i].e_bak | vecs[i].e_rak) begin
            check($sformatf("vec%0d_addr", i), ram_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_data", i), ram_wdata, vecs[i].e_data);
         end
         @(negedge Clk);
      end
      Blue_req = 1'b0;
      Red_req  = 1'b0;

      run_load(2, 2, 1'b0, 1'b0, 1'b1);
      run_load(0, 0, 1'b0, 1'b1, 1'b0);
      run_load(1, 3, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a load.
      background_select = 2'd0;
      load_background   = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      load_background = 1'b0;
      repeat (6) @(negedge Clk);
      check("pre_rst_we", ram_we, 1);
      check("pre_rst_busy", load_busy, 1);
      Blue_req = 1'b1;
      Red_req  = 1'b1;
      #1;
      check("load_acks", {Blue_ack, Red_ack}, 0);
      #1;
      Reset_n = 1'b0;
      #1;
      check("rst_mid_we", ram_we, 0);
      check("rst_mid_busy", load_busy, 0);
      check("rst_mid_acks", {Blue_ack, Red_ack}, 0);
      check("rst_mid_rom_addr", rom_addr, 0);
      done_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         if (load_done) done_cnt++;
      end
      check("rst_mid_no_done", done_cnt, 0);
      Blue_req = 1'b0;
      Red_req  = 1'b0;
      Reset_n  = 1'b1;
      @(negedge Clk);
      check("post_rst_busy", load_busy, 0);
      run_load(3, 3, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
